core_dmem: RTL and testbench
============================

# core_dmem

Pipelined Wishbone data-memory slave: the responder at the far end of the core's memory-access bus, serving LD/ST traffic issued by the core's pipelined bus master. It holds a byte-lane-writable word array, accepts at most one request per cycle, returns in-order acks after a fixed latency, and raises stall when its outstanding-request budget is exhausted.

## Interface
- DEPTH_WORDS, 1024: number of 32-bit words; power of two; AW = log2(DEPTH_WORDS).
- LATENCY, 3: cycles from request acceptance to ack; legal range 1..8.
- MAX_OUT, 2: maximum accepted-but-unacked requests; legal range 1..LATENCY.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- The bus signals arrive through the `wishbone.pl_slave` modport, as follows.
- bus.cyc  in  1  bus cycle active.
- bus.stb  in  1  request strobe.
- bus.we  in  1  1 = write, 0 = read.
- bus.sel  in  4  byte-lane enables: 0001 byte, 0011 halfword, 1111 word.
- bus.adr  in  32  byte address; word index = adr[AW+1:2], adr[1:0] and upper bits ignored (wrap).
- bus.dat_ms  in  32  write data.
- bus.dat_so  out  32  read data, valid with ack.
- bus.ack  out  1  one-cycle completion pulse per accepted request.
- bus.stall  out  1  request not accepted this cycle.

## Operation
- Acceptance: in a cycle where cyc & stb & !stall, the request is accepted at the rising edge.
- Write: on acceptance, lanes with sel[i]=1 take dat_ms[8i+7:8i]; other lanes unchanged. Commit occurs at the acceptance edge.
- Read: the word is sampled at the acceptance edge, after any write committed at an earlier edge. Lanes with sel[i]=0 return zero.
- Write ack carries dat_so = 0.
- Pipeline: LATENCY stages, each holding {valid, data}. An accepted request enters stage 1 and advances one stage per cycle. ack = valid of stage LATENCY; dat_so = data of stage LATENCY. Ordering is strictly FIFO.
- Outstanding counter cnt (0..MAX_OUT): +1 on accept, -1 on ack, unchanged when both occur.
- stall = (cnt == MAX_OUT) & !ack. This allows back-to-back acceptance when the oldest request retires that cycle. stall is driven only by registers, never by bus inputs.
- Abort: if cyc is low in any cycle, all stage valids and cnt clear at that edge.
  - No ack is issued for aborted requests.
  - Writes already committed stay committed.
  - stb while cyc is low is ignored.
- Reset:
  - ack = 0, dat_so = 0, all stage valids = 0, cnt = 0, stall = 0.
  - Memory contents are not reset.
  - rst has priority over accept and abort.

## Timing
- Request accepted at edge N: ack is high in the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after the request cycle. LATENCY=1 gives ack in the cycle right after the request.
- Throughput: one per cycle while cnt < MAX_OUT. With MAX_OUT < LATENCY, sustained rate is MAX_OUT requests per LATENCY cycles.
- Simultaneous ack and new request at cnt == MAX_OUT: the request is accepted and cnt stays at MAX_OUT.
- Write then read to the same word on consecutive cycles: the read returns the new data.
- Read then write to the same word on consecutive cycles: the read returns the old data.
- Reset asserted mid-transfer: ack is 0 on the cycle after the reset edge; the first request after reset is accepted when rst is low.

## Structure
- Shared package i2d_core_defines gets the sel constants WB_SEL_B = 4'b0001, WB_SEL_W = 4'b0011, WB_SEL_D = 4'b1111, plus a dmem_stage_t struct {valid, data[31:0]}.
- One sub-module, core_dmem_ram: DEPTH_WORDS×32 array with 4 byte-write enables, synchronous write, combinational read. core_dmem holds the acceptance logic, pipeline, counter and stall.

## Test plan
- Reset, then word write adr 0x10 data 0xDEADBEEF sel 1111, then read adr 0x10 → ack 3 cycles after each request; read dat_so = 0xDEADBEEF.
- Byte write adr 0x10 sel 0001 data 0x000000AA over 0xDEADBEEF, then word read → 0xDEADBEAA. Halfword read sel 0011 → 0x0000BEAA.
- 6 back-to-back reads, cyc and stb held high, LATENCY=3, MAX_OUT=2 → stall high in the 3rd request cycle. Acks are in order and total 6. cnt never exceeds 2.
- Write 0x11111111 then read of the same word on the next cycle → read returns 0x11111111. Read then write on the next cycle → read returns the old value.
- Two reads accepted, then cyc dropped for 1 cycle → no acks, stall = 0, and a following request acks normally after 3 cycles.
- rst pulsed while 2 requests are outstanding → ack, stall and dat_so are 0 on the next cycle; memory keeps 0xDEADBEAA at 0x10.

Source files
------------

// File: rtl/i2d_core_defines.sv
// Shared core definitions: Wishbone byte-lane select codes and dmem pipeline stage type.
package i2d_core_defines;

    localparam logic [3:0] WB_SEL_B = 4'b0001;
    localparam logic [3:0] WB_SEL_W = 4'b0011;
    localparam logic [3:0] WB_SEL_D = 4'b1111;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } dmem_stage_t;

    // Expand a 4-bit lane select into a 32-bit byte mask.
    function automatic logic [31:0] sel_mask(input logic [3:0] sel);
        return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    endfunction

endpackage

// File: rtl/wishbone.sv
// Pipelined Wishbone bus bundle with master and slave views.
interface wishbone;

    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_so;
    logic        ack;
    logic        stall;

    modport pl_slave (
        input  cyc, stb, we, sel, adr, dat_ms,
        output dat_so, ack, stall
    );

    modport pl_master (
        output cyc, stb, we, sel, adr, dat_ms,
        input  dat_so, ack, stall
    );

endinterface

// File: rtl/core_dmem_ram.sv
// Word array with per-byte write enables, synchronous write and combinational read.
module core_dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Commit enabled byte lanes of the write data.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/core_dmem.sv
// Pipelined Wishbone data-memory slave: fixed-latency in-order acks, bounded outstanding requests.
module core_dmem
    import i2d_core_defines::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 3,
    parameter int unsigned MAX_OUT     = 2
) (
    input  logic      clk,
    input  logic      rst,
    wishbone.pl_slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUT);

    dmem_stage_t   stage_q [LATENCY];
    dmem_stage_t   stage_d [LATENCY];
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          accept;
    logic          ack;
    logic          stall;
    logic [31:0]   rdata;
    logic [AW-1:0] widx;
    logic          unused_adr;

    assign widx       = bus.adr[AW+1:2];
    assign unused_adr = ^{bus.adr[31:AW+2], bus.adr[1:0]};

    assign ack    = stage_q[LATENCY-1].valid;
    assign stall  = (cnt_q == CNT_MAX) & ~ack;
    assign accept = bus.cyc & bus.stb & ~stall;

    core_dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk_i  (clk),
        .we_i   (accept & bus.we),
        .be_i   (bus.sel),
        .addr_i (widx),
        .wdata_i(bus.dat_ms),
        .rdata_o(rdata)
    );

    // Shift the response pipeline; a dropped cyc kills every in-flight request.
    always_comb begin
        for (int unsigned i = 0; i < LATENCY; i++) begin
            stage_d[i] = '0;
        end
        stage_d[0].valid = accept;
        stage_d[0].data  = (accept && !bus.we) ? (rdata & sel_mask(bus.sel)) : '0;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        if (!bus.cyc) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_d[i].valid = 1'b0;
            end
        end
    end

    // Outstanding-request count: up on accept, down on ack, cleared on abort.
    always_comb begin
        cnt_d = cnt_q;
        if (!bus.cyc) begin
            cnt_d = '0;
        end else if (accept && !ack) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && ack) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pipeline and counter registers; reset overrides accept and abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= stage_d[i];
            end
            cnt_q <= cnt_d;
        end
    end

    assign bus.ack    = ack;
    assign bus.stall  = stall;
    assign bus.dat_so = stage_q[LATENCY-1].data;

endmodule

// File: tb/tb_core_dmem.sv
// Scoreboard bench for core_dmem (LATENCY=3, MAX_OUT=2).
module tb_core_dmem;
    import i2d_core_defines::*;

    typedef struct {
        logic [31:0] data;
        logic        we;
        int unsigned cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    wishbone bus ();

    exp_t        sbq[$];
    logic [31:0] model [1024];
    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cyc_n = 0;
    int unsigned ack_count = 0;
    int unsigned max_os = 0;
    logic [31:0] last_rd = '0;

    core_dmem #(
        .DEPTH_WORDS(1024),
        .LATENCY    (3),
        .MAX_OUT    (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: retire acks, then predict the request accepted at the coming edge.
    always @(negedge clk) begin
        exp_t e;
        logic [9:0] idx;
        cyc_n++;
        if (bus.ack) begin
            ack_count++;
            if (sbq.size() == 0) begin
                check("ack_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("ack_data", bus.dat_so, e.data);
                check("ack_latency", cyc_n - e.cyc, 32'd3);
                if (!e.we) last_rd = bus.dat_so;
            end
        end
        if (rst || !bus.cyc) begin
            sbq.delete();
        end else if (bus.stb && !bus.stall) begin
            idx    = bus.adr[11:2];
            e.we   = bus.we;
            e.cyc  = cyc_n;
            if (bus.we) begin
                e.data = '0;
                model[idx] = (model[idx] & ~sel_mask(bus.sel)) | (bus.dat_ms & sel_mask(bus.sel));
            end else begin
                e.data = model[idx] & sel_mask(bus.sel);
            end
            sbq.push_back(e);
            if (sbq.size() > max_os) max_os = sbq.size();
        end
    end

    // Issue one request starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic req(input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output logic stalled);
        int unsigned n = 0;
        bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = w;
        bus.sel = s; bus.adr = a; bus.dat_ms = d;
        @(negedge clk);
        stalled = bus.stall;
        while (bus.stall && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("stall_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int unsigned n = 0;
        bus.stb = 1'b0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       st;
        logic [5:0] stall_pat;
        logic [5:0] stall_seen;
        int unsigned a0;

        bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
        bus.sel = '0; bus.adr = '0; bus.dat_ms = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'd0, bus.ack}, 32'd0);
        check("rst_stall", {31'd0, bus.stall}, 32'd0);
        check("rst_dat_so", bus.dat_so, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Word write then word read
        req(1'b1, WB_SEL_D, 32'h10, 32'hDEADBEEF, st);
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        drain();
        check("word_read", last_rd, 32'hDEADBEEF);

        // Byte write then word and halfword reads
        req(1'b1, WB_SEL_B, 32'h10, 32'h000000AA, st);
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        drain();
        check("byte_merge", last_rd, 32'hDEADBEAA);
        req(1'b0, WB_SEL_W, 32'h10, 32'h0, st);
        drain();
        check("half_read", last_rd, 32'h0000BEAA);

        // Six back-to-back reads against a prefilled region
        for (int k = 0; k < 6; k++) begin
            req(1'b1, WB_SEL_D, 32'h40 + 4 * k, 32'hA0000000 + k, st);
        end
        drain();
        max_os    = 0;
        a0        = ack_count;
        stall_pat = 6'b010100;
        for (int k = 0; k < 6; k++) begin
            req(1'b0, WB_SEL_D, 32'h40 + 4 * k, 32'h0, st);
            stall_seen[k] = st;
        end
        drain();
        check("burst_stall_pattern", {26'd0, stall_seen}, {26'd0, stall_pat});
        check("burst_ack_total", ack_count - a0, 32'd6);
        check("burst_max_outstanding", max_os, 32'd2);
        check("burst_last", last_rd, 32'hA0000005);

        // Read-after-write and write-after-read to the same word
        req(1'b1, WB_SEL_D, 32'h80, 32'h11111111, st);
        req(1'b0, WB_SEL_D, 32'h80, 32'h0, st);
        drain();
        check("raw_new", last_rd, 32'h11111111);
        req(1'b0, WB_SEL_D, 32'h80, 32'h0, st);
        req(1'b1, WB_SEL_D, 32'h80, 32'h22222222, st);
        drain();
        check("war_old", last_rd, 32'h11111111);
        req(1'b0, WB_SEL_D, 32'h80, 32'h0, st);
        drain();
        check("war_after", last_rd, 32'h22222222);

        // Abort: two reads in flight, cyc dropped for one cycle
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        bus.cyc = 1'b0; bus.stb = 1'b0;
        @(posedge clk);
        #1;
        bus.cyc = 1'b1;
        a0 = ack_count;
        check("abort_stall", {31'd0, bus.stall}, 32'd0);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_ack", ack_count - a0, 32'd0);
        last_rd = '0;
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        drain();
        check("abort_resume", last_rd, 32'hDEADBEAA);

        // Reset with two outstanding requests
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        rst = 1'b1; bus.stb = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ack", {31'd0, bus.ack}, 32'd0);
        check("midrst_stall", {31'd0, bus.stall}, 32'd0);
        check("midrst_dat_so", bus.dat_so, 32'd0);
        rst = 1'b0;
        last_rd = '0;
        req(1'b0, WB_SEL_D, 32'h10, 32'h0, st);
        drain();
        check("midrst_mem_kept", last_rd, 32'hDEADBEAA);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
